vedic_seq_mul_ctrl: RTL and testbench
=====================================

Name: vedic_seq_mul_ctrl

Overview:
- Sequencing controller that builds a full OPERAND_W x OPERAND_W product from one shared half-width (OPERAND_W/2) Vedic multiplier core, time-multiplexed over four passes.
- Latches operands on a start handshake, steers operand halves into the core one pass at a time, and shift-accumulates the partial products.
- Presents the product with a one-cycle done pulse.
- Sits between the operand source and the NAND-built multiplier datapath; the core itself is combinational.

Parameters:
- OPERAND_W, 8, full operand width; must be even and >= 4; core width H = OPERAND_W/2.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  OPERAND_W  multiplicand, sampled when start is accepted
- b  input  OPERAND_W  multiplier, sampled when start is accepted
- busy  output  1  high from the accept edge until done is asserted
- done  output  1  one-cycle pulse; product valid
- product  output  2*OPERAND_W  result register, held until the next completion
- pass_idx  output  2  current pass number (debug/observation)

Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.

Behaviour:
- Reset (asynchronous, immediate on rst_n low): state=IDLE; busy=0, done=0, product=0, pass_idx=0; internal accumulator and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: when start=1 at an edge (E0):
  - latch a, b;
  - clear accumulator;
  - pass_idx=0, busy=1;
  - go to RUN.
- RUN, one pass per edge E1..E4. The core is fed with operand halves (L = [H-1:0], H = [OPERAND_W-1:H]):
  - pass 0: aL*bL, accumulated unshifted
  - pass 1: aH*bL, accumulated << H
  - pass 2: aL*bH, accumulated << H
  - pass 3: aH*bH, accumulated << 2H
- Accumulator is 2*OPERAND_W bits, unsigned; no overflow is possible, and the carry out of the MSB is discarded by construction.
- pass_idx increments after each pass.
- At E4 (pass 3): product <= final sum; done <= 1; busy <= 0; go to DONE.
- DONE: lasts exactly one cycle; at the next edge done <= 0 and state goes to IDLE.
  - start is not accepted in DONE. Earliest re-accept is the edge after DONE, i.e. E5 at the earliest.
- Latency: done is high in the cycle following E4 (4 edges after accept).
- start while busy or in DONE: ignored; operands are not resampled.
- a/b may change after acceptance without affecting the result.
- product holds its last value through IDLE and RUN and changes only at completion; it is never exposed partially accumulated.
- rst_n asserted mid-operation: computation is abandoned and all outputs return to reset values immediately; no done is produced.
- Core instantiation: exactly one H x H core; no second multiplier is permitted.

Optional Feature:
- Macro: VEDIC_ZERO_SKIP_EN.
- Defined: at accept, if a==0 or b==0, skip RUN. At E1: product <= 0, done <= 1, busy <= 0, state goes to DONE, pass_idx stays 0. Latency is 1 edge after accept.
- Undefined: zero operands take the normal four passes; product=0 and done arrives at E4.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> product=16'h0000, busy=0, done=0; no activity for 10 cycles with start=0.
- Basic: a=8'h0C, b=8'h0A, start pulse -> busy high E0..E4, done high exactly one cycle after E4, product=16'h0078, pass_idx sequence 0,1,2,3.
- Extremes, back to back: a=8'hFF, b=8'hFF -> 16'hFE01; start held high continuously, next a=8'hA5, b=8'h3C accepted at the first edge after DONE -> 16'h26AC; each done is a single-cycle pulse.
- Start while busy: accept 8'h12*8'h34; at E2 pulse start with a=8'hFF, b=8'hFF -> ignored, product=16'h03A8, exactly one done.
- Reset mid-op: accept 8'h77*8'h88, assert rst_n low between E2 and E3 -> outputs cleared asynchronously, no done; after release, 8'h03*8'h05 -> 16'h000F.
- Zero operand: a=8'h00, b=8'h37 -> product=0. With VEDIC_ZERO_SKIP_EN, done follows E1; without it, done follows E4.

Source files
------------

// File: rtl/vedic_seq_mul_ctrl.sv
// Sequential OPERAND_W x OPERAND_W multiplier built from one shared H x H Vedic (Urdhva
// Tiryagbhyam) core over four passes. Optional macro VEDIC_ZERO_SKIP_EN finishes zero-operand jobs early.

module vedic_core_hxh #(
  parameter int W = 4
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);

  // Vertical-and-crosswise: column k holds the count of a[i]&b[k-i] terms.
  function automatic logic [CW-1:0] col_count(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input int k);
    logic [W-1:0]  tx;
    logic [W-1:0]  ty;
    logic [CW-1:0] cnt;
    cnt = '0;
    tx  = '0;
    ty  = '0;
    for (int i = 0; i < W; i++) begin
      if ((k - i) >= 0 && (k - i) < W) begin
        tx  = x >> i;
        ty  = y >> (k - i);
        cnt = cnt + CW'(tx[0] & ty[0]);
      end
    end
    return cnt;
  endfunction

  logic [CW-1:0] w_col [2*W-1];
  logic [PW-1:0] w_p;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * W - 1; gi++) begin : g_col
      assign w_col[gi] = col_count(i_a, i_b, gi);
    end
  endgenerate

  always_comb begin
    w_p = '0;
    for (int k = 0; k < 2 * W - 1; k++) begin
      w_p = w_p + (PW'(w_col[k]) << k);
    end
  end

  assign o_p = w_p;
endmodule

module vedic_seq_mul_ctrl #(
  parameter int OPERAND_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [OPERAND_W-1:0]   a,
  input  logic [OPERAND_W-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [2*OPERAND_W-1:0] product,
  output logic [1:0]             pass_idx
);
  localparam int H  = OPERAND_W / 2;
  localparam int PW = 2 * OPERAND_W;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t               r_state, w_state_next;
  logic [OPERAND_W-1:0] r_a, w_a_next;
  logic [OPERAND_W-1:0] r_b, w_b_next;
  logic [PW-1:0]        r_acc, w_acc_next;
  logic [PW-1:0]        r_product, w_product_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic [1:0]           r_pass, w_pass_next;
`ifdef VEDIC_ZERO_SKIP_EN
  logic                 r_zero, w_zero_next;
`endif

  logic [H-1:0]         w_core_a;
  logic [H-1:0]         w_core_b;
  logic [2*H-1:0]       w_core_p;
  logic [PW-1:0]        w_pp_shift;
  logic [PW-1:0]        w_acc_sum;
  logic                 w_accept;

  // Pass bit 0 selects the high half of a, bit 1 the high half of b.
  assign w_core_a = r_pass[0] ? r_a[OPERAND_W-1:H] : r_a[H-1:0];
  assign w_core_b = r_pass[1] ? r_b[OPERAND_W-1:H] : r_b[H-1:0];

  vedic_core_hxh #(.W(H)) u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_core_p)
  );

  always_comb begin
    case (r_pass)
      2'd0:    w_pp_shift = PW'(w_core_p);
      2'd3:    w_pp_shift = PW'(w_core_p) << (2 * H);
      default: w_pp_shift = PW'(w_core_p) << H;
    endcase
  end

  assign w_acc_sum = r_acc + w_pp_shift;
  // start is sampled at the IDLE edges and at the edge that closes the DONE cycle.
  assign w_accept  = start && (r_state == ST_IDLE || r_state == ST_DONE);

  always_comb begin
    w_state_next   = r_state;
    w_a_next       = r_a;
    w_b_next       = r_b;
    w_acc_next     = r_acc;
    w_product_next = r_product;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_pass_next    = r_pass;
`ifdef VEDIC_ZERO_SKIP_EN
    w_zero_next    = r_zero;
`endif
    case (r_state)
      ST_IDLE: w_state_next = ST_IDLE;
      ST_RUN: begin
`ifdef VEDIC_ZERO_SKIP_EN
        if (r_zero) begin
          w_product_next = '0;
          w_done_next    = 1'b1;
          w_busy_next    = 1'b0;
          w_state_next   = ST_DONE;
        end else begin
`else
        begin
`endif
          w_acc_next  = w_acc_sum;
          w_pass_next = r_pass + 2'd1;
          if (r_pass == 2'd3) begin
            w_product_next = w_acc_sum;
            w_done_next    = 1'b1;
            w_busy_next    = 1'b0;
            w_state_next   = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_accept) begin
      w_a_next     = a;
      w_b_next     = b;
      w_acc_next   = '0;
      w_pass_next  = 2'd0;
      w_busy_next  = 1'b1;
      w_state_next = ST_RUN;
`ifdef VEDIC_ZERO_SKIP_EN
      w_zero_next  = (a == '0) || (b == '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 2'd0;
`ifdef VEDIC_ZERO_SKIP_EN
      r_zero    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_a       <= w_a_next;
      r_b       <= w_b_next;
      r_acc     <= w_acc_next;
      r_product <= w_product_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_pass    <= w_pass_next;
`ifdef VEDIC_ZERO_SKIP_EN
      r_zero    <= w_zero_next;
`endif
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign product  = r_product;
  assign pass_idx = r_pass;
endmodule

// File: tb/tb_vedic_seq_mul_ctrl.sv
// Directed self-checking bench for vedic_seq_mul_ctrl (8-bit operands).
module tb_vedic_seq_mul_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [1:0]  pass_idx;

  int errors = 0;
  int checks = 0;

  vedic_seq_mul_ctrl #(.OPERAND_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .pass_idx (pass_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) tick();
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass_idx !== 2'd0) begin errors++; $display("FAIL reset_pass: got %0d expected 0", pass_idx); end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
        errors++; $display("FAIL idle_quiet c%0d: got busy=%b done=%b product=%h expected 0 0 0000", c, busy, done, product);
      end
    end
    $display("reset/idle: product=%h busy=%b done=%b", product, busy, done);
  endtask

  task automatic test_basic();
    a = 8'h0C; b = 8'h0A; start = 1'b1;
    tick();
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || pass_idx !== p[1:0] || product !== 16'h0000) begin
        errors++; $display("FAIL basic_run p%0d: got busy=%b done=%b pass=%0d product=%h expected 1 0 %0d 0000", p, busy, done, pass_idx, product, p);
      end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done: got done=%b busy=%b expected 1 0", done, busy); end
    checks++; if (product !== 16'h0078) begin errors++; $display("FAIL basic_product: got %h expected 0078", product); end
    tick();
    checks++; if (done !== 1'b0 || product !== 16'h0078) begin errors++; $display("FAIL basic_after: got done=%b product=%h expected 0 0078", done, product); end
    $display("basic 0C*0A: product=%h", product);
  endtask

  task automatic test_back_to_back();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    a = 8'hA5; b = 8'h3C;
    for (int p = 0; p < 4; p++) begin
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_run1 p%0d: got done=%b busy=%b expected 0 1", p, done, busy); end
      tick();
    end
    checks++; if (done !== 1'b1 || product !== 16'hFE01) begin errors++; $display("FAIL b2b_first: got done=%b product=%h expected 1 FE01", done, product); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b1 || pass_idx !== 2'd0) begin errors++; $display("FAIL b2b_reaccept: got done=%b busy=%b pass=%0d expected 0 1 0", done, busy, pass_idx); end
    start = 1'b0; a = 8'h00; b = 8'h00;
    for (int p = 1; p < 4; p++) begin
      tick();
      checks++; if (done !== 1'b0 || product !== 16'hFE01) begin errors++; $display("FAIL b2b_run2 p%0d: got done=%b product=%h expected 0 FE01", p, done, product); end
    end
    tick();
    checks++; if (done !== 1'b1 || product !== 16'h26AC) begin errors++; $display("FAIL b2b_second: got done=%b product=%h expected 1 26AC", done, product); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: got done=%b busy=%b expected 0 0", done, busy); end
    $display("back_to_back FF*FF then A5*3C: product=%h", product);
  endtask

  task automatic test_start_while_busy();
    int n_done;
    n_done = 0;
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_done += int'(done);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    tick();
    n_done += int'(done);
    start = 1'b0;
    tick();
    n_done += int'(done);
    tick();
    n_done += int'(done);
    checks++; if (done !== 1'b1 || product !== 16'h03A8) begin errors++; $display("FAIL busy_ignore_product: got done=%b product=%h expected 1 03A8", done, product); end
    repeat (3) begin
      tick();
      n_done += int'(done);
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_ignore_count: got %0d done pulses expected 1", n_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle: got busy=%b expected 0", busy); end
    $display("start_while_busy 12*34: product=%h dones=%0d", product, n_done);
  endtask

  task automatic test_reset_midop();
    a = 8'h77; b = 8'h88; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || pass_idx !== 2'd0) begin
      errors++; $display("FAIL midop_async: got busy=%b done=%b product=%h pass=%0d expected 0 0 0000 0", busy, done, product, pass_idx);
    end
    repeat (3) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midop_nodone: got done=%b expected 0", done); end
    end
    rst_n = 1'b1;
    tick();
    a = 8'h03; b = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++; if (done !== 1'b1 || product !== 16'h000F) begin errors++; $display("FAIL midop_after: got done=%b product=%h expected 1 000F", done, product); end
    tick();
    $display("reset_midop then 03*05: product=%h", product);
  endtask

  task automatic test_zero();
    a = 8'h00; b = 8'h37; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || product !== 16'h000F) begin errors++; $display("FAIL zero_accept: got busy=%b product=%h expected 1 000F", busy, product); end
`ifdef VEDIC_ZERO_SKIP_EN
    tick();
    checks++;
    if (done !== 1'b1 || product !== 16'h0000 || busy !== 1'b0 || pass_idx !== 2'd0) begin
      errors++; $display("FAIL zero_skip: got done=%b product=%h busy=%b pass=%0d expected 1 0000 0 0", done, product, busy, pass_idx);
    end
`else
    for (int p = 1; p < 4; p++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_run p%0d: got done=%b expected 0", p, done); end
    end
    tick();
    checks++; if (done !== 1'b1 || product !== 16'h0000) begin errors++; $display("FAIL zero_full: got done=%b product=%h expected 1 0000", done, product); end
`endif
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b expected 0", done); end
    $display("zero 00*37: product=%h", product);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_while_busy();
    test_reset_midop();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
